// File: rtl/axil_cmd_master.sv
// rtl/axil_cmd_master.sv - single-beat command/response bridge onto an AXI4-lite master port
// One transaction in flight; each response carries a saturating accept-to-handshake cycle count.
module axil_cmd_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH/8,
  parameter int LAT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb,
  input  logic [2:0]            cmd_prot,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic [LAT_WIDTH-1:0]  rsp_latency,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5
  } state_t;

  localparam logic [LAT_WIDTH-1:0] LAT_MAX = '1;

  state_t state_q, state_d;

  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [2:0]            awprot_q, awprot_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [2:0]            arprot_q, arprot_d;

  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_write_q, rsp_write_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]            rsp_resp_q, rsp_resp_d;
  logic [LAT_WIDTH-1:0]  rsp_latency_q, rsp_latency_d;

  logic [LAT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [LAT_WIDTH-1:0]  cnt_inc;

  // Saturating increment shared by the running count and the reported latency.
  assign cnt_inc = (cnt_q == LAT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      awaddr_q      <= '0;
      awprot_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      araddr_q      <= '0;
      arprot_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_write_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= '0;
      rsp_latency_q <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      awaddr_q      <= awaddr_d;
      awprot_q      <= awprot_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      araddr_q      <= araddr_d;
      arprot_q      <= arprot_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_write_q   <= rsp_write_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_latency_q <= rsp_latency_d;
      cnt_q         <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    awaddr_d      = awaddr_q;
    awprot_d      = awprot_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    araddr_d      = araddr_q;
    arprot_d      = arprot_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_write_d   = rsp_write_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_latency_d = rsp_latency_q;
    cnt_d         = cnt_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cnt_d = '0;
          if (cmd_write) begin
            awaddr_d  = cmd_addr;
            awprot_d  = cmd_prot;
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_REQ;
          end else begin
            araddr_d  = cmd_addr;
            arprot_d  = cmd_prot;
            arvalid_d = 1'b1;
            state_d   = RD_REQ;
          end
        end
      end

      // AW and W complete independently; B is only accepted once both are gone.
      WR_REQ: begin
        cnt_d = cnt_inc;
        if (m_axil_awready) awvalid_d = 1'b0;
        if (m_axil_wready)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end

      WR_RESP: begin
        cnt_d = cnt_inc;
        if (m_axil_bvalid) begin
          rsp_resp_d    = m_axil_bresp;
          rsp_rdata_d   = '0;
          rsp_write_d   = 1'b1;
          rsp_valid_d   = 1'b1;
          rsp_latency_d = cnt_inc;
          bready_d      = 1'b0;
          state_d       = RSP;
        end
      end

      RD_REQ: begin
        cnt_d = cnt_inc;
        if (m_axil_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_RESP;
        end
      end

      RD_RESP: begin
        cnt_d = cnt_inc;
        if (m_axil_rvalid) begin
          rsp_resp_d    = m_axil_rresp;
          rsp_rdata_d   = m_axil_rdata;
          rsp_write_d   = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_latency_d = cnt_inc;
          rready_d      = 1'b0;
          state_d       = RSP;
        end
      end

      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready      = (state_q == IDLE);
  assign rsp_valid      = rsp_valid_q;
  assign rsp_write      = rsp_write_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_resp       = rsp_resp_q;
  assign rsp_latency    = rsp_latency_q;
  assign m_axil_awaddr  = awaddr_q;
  assign m_axil_awprot  = awprot_q;
  assign m_axil_awvalid = awvalid_q;
  assign m_axil_wdata   = wdata_q;
  assign m_axil_wstrb   = wstrb_q;
  assign m_axil_wvalid  = wvalid_q;
  assign m_axil_bready  = bready_q;
  assign m_axil_araddr  = araddr_q;
  assign m_axil_arprot  = arprot_q;
  assign m_axil_arvalid = arvalid_q;
  assign m_axil_rready  = rready_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// tb/tb_axil_cmd_master.sv - directed bench for axil_cmd_master against a transaction-level model
module tb_axil_cmd_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic [2:0]  cmd_prot = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [15:0] rsp_latency;
  logic [31:0] awaddr, wdata, araddr, rdata = '0;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
  logic [1:0]  bresp = '0, rresp = '0;
  logic        bvalid = 1'b0, bready, arvalid, arready = 1'b0;
  logic        rvalid = 1'b0, rready;

  int errors = 0;
  int checks = 0;

  axil_cmd_master dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_latency(rsp_latency),
    .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid), .m_axil_awready(awready),
    .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid), .m_axil_wready(wready),
    .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(bready),
    .m_axil_araddr(araddr), .m_axil_arprot(arprot), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
    .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid), .m_axil_rready(rready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: which phases of the current command have completed.
  bit          m_busy, m_wr, aw_seen, w_seen, b_seen, ar_seen, r_seen;
  logic [31:0] m_addr, m_data, m_rdata;
  logic [3:0]  m_strb;
  logic [2:0]  m_prot;
  logic [1:0]  m_resp;
  longint      cyc = 0, acc_cyc = 0, m_lat = 0;

  always @(negedge clk) begin
    bit e_aw, e_w, e_b, e_ar, e_r, e_rsp;
    cyc++;
    if (rst) begin
      chk("rst_awvalid", 64'(awvalid), 64'd0);
      chk("rst_wvalid", 64'(wvalid), 64'd0);
      chk("rst_bready", 64'(bready), 64'd0);
      chk("rst_arvalid", 64'(arvalid), 64'd0);
      chk("rst_rready", 64'(rready), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      m_busy = 0;
    end else begin
      e_aw  = m_busy && m_wr && !aw_seen;
      e_w   = m_busy && m_wr && !w_seen;
      e_b   = m_busy && m_wr && aw_seen && w_seen && !b_seen;
      e_ar  = m_busy && !m_wr && !ar_seen;
      e_r   = m_busy && !m_wr && ar_seen && !r_seen;
      e_rsp = m_busy && (b_seen || r_seen);
      chk("cmd_ready", 64'(cmd_ready), 64'(!m_busy));
      chk("awvalid", 64'(awvalid), 64'(e_aw));
      chk("wvalid", 64'(wvalid), 64'(e_w));
      chk("bready", 64'(bready), 64'(e_b));
      chk("arvalid", 64'(arvalid), 64'(e_ar));
      chk("rready", 64'(rready), 64'(e_r));
      chk("rsp_valid", 64'(rsp_valid), 64'(e_rsp));
      if (e_aw) begin
        chk("awaddr", 64'(awaddr), 64'(m_addr));
        chk("awprot", 64'(awprot), 64'(m_prot));
      end
      if (e_w) begin
        chk("wdata", 64'(wdata), 64'(m_data));
        chk("wstrb", 64'(wstrb), 64'(m_strb));
      end
      if (e_ar) begin
        chk("araddr", 64'(araddr), 64'(m_addr));
        chk("arprot", 64'(arprot), 64'(m_prot));
      end
      if (e_rsp) begin
        chk("rsp_write", 64'(rsp_write), 64'(m_wr));
        chk("rsp_rdata", 64'(rsp_rdata), 64'(m_rdata));
        chk("rsp_resp", 64'(rsp_resp), 64'(m_resp));
        chk("rsp_latency", 64'(rsp_latency), 64'(m_lat));
      end
      // Advance the model using the expected DUT handshakes and the bench-driven inputs.
      if (!m_busy) begin
        if (cmd_valid) begin
          m_busy = 1; m_wr = cmd_write; m_addr = cmd_addr; m_data = cmd_wdata;
          m_strb = cmd_wstrb; m_prot = cmd_prot; acc_cyc = cyc;
          aw_seen = 0; w_seen = 0; b_seen = 0; ar_seen = 0; r_seen = 0;
        end
      end else begin
        if (e_aw && awready) aw_seen = 1;
        if (e_w && wready) w_seen = 1;
        if (e_ar && arready) ar_seen = 1;
        if ((e_b && bvalid) || (e_r && rvalid)) begin
          m_lat   = (cyc - acc_cyc > 65535) ? 65535 : cyc - acc_cyc;
          m_resp  = e_b ? bresp : rresp;
          m_rdata = e_b ? 32'd0 : rdata;
          if (e_b) b_seen = 1; else r_seen = 1;
        end
        if (e_rsp && rsp_ready) m_busy = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [2:0] p);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_prot = p;
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Write, slave always ready: rsp in cycle 3, latency 2.
    chk("t1_cmd_ready_c0", 64'(cmd_ready), 64'd1);
    send(1'b1, 32'h10, 32'hA5A5A5A5, 4'hF, 3'b010);
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'd0;
    tick();
    cmd_valid = 1'b0;
    chk("t1_awvalid_c1", 64'(awvalid), 64'd1);
    chk("t1_awaddr_c1", 64'(awaddr), 64'h10);
    tick();
    chk("t1_bready_c2", 64'(bready), 64'd1);
    chk("t1_rsp_valid_c2", 64'(rsp_valid), 64'd0);
    tick();
    chk("t1_rsp_valid_c3", 64'(rsp_valid), 64'd1);
    chk("t1_latency", 64'(rsp_latency), 64'd2);
    chk("t1_rsp_write", 64'(rsp_write), 64'd1);
    rsp_ready = 1'b1; bvalid = 1'b0;
    tick();
    rsp_ready = 1'b0;
    chk("t1_cmd_ready_after", 64'(cmd_ready), 64'd1);

    // Write with awready held low for cycles 1-3.
    send(1'b1, 32'h44, 32'h0BADF00D, 4'h5, 3'b001);
    awready = 1'b0; wready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("t2_wvalid_c2", 64'(wvalid), 64'd0);
    tick();
    chk("t2_awvalid_c3", 64'(awvalid), 64'd1);
    tick();
    awready = 1'b1;
    tick();
    awready = 1'b0;
    chk("t2_bready_c5", 64'(bready), 64'd1);
    bvalid = 1'b1; bresp = 2'd1;
    tick();
    bvalid = 1'b0;
    chk("t2_latency", 64'(rsp_latency), 64'd5);
    chk("t2_rsp_resp", 64'(rsp_resp), 64'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Read with rvalid delayed 4 cycles after rready rises.
    send(1'b0, 32'h20, 32'h0, 4'h0, 3'b100);
    arready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("t3_arvalid_c1", 64'(arvalid), 64'd1);
    tick();
    arready = 1'b0;
    repeat (4) begin
      chk("t3_rready_wait", 64'(rready), 64'd1);
      tick();
    end
    rvalid = 1'b1; rdata = 32'hDEADBEEF; rresp = 2'd2;
    tick();
    rvalid = 1'b0;
    chk("t3_rsp_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
    chk("t3_rsp_resp", 64'(rsp_resp), 64'd2);
    chk("t3_latency", 64'(rsp_latency), 64'd6);

    // Response stalled 10 cycles with a command waiting.
    send(1'b1, 32'h30, 32'h12345678, 4'h3, 3'b101);
    for (int i = 0; i < 10; i++) begin
      chk("t4_cmd_ready_stall", 64'(cmd_ready), 64'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("t4_cmd_ready_resume", 64'(cmd_ready), 64'd1);
    awready = 1'b1; wready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("t4_awvalid", 64'(awvalid), 64'd1);
    chk("t4_awaddr", 64'(awaddr), 64'h30);
    tick();
    awready = 1'b0; wready = 1'b0;

    // Reset while waiting in WR_RESP.
    chk("t5_bready_pre", 64'(bready), 64'd1);
    rst = 1'b1;
    #1;
    chk("t5_bready_now", 64'(bready), 64'd0);
    chk("t5_cmd_ready_now", 64'(cmd_ready), 64'd1);
    chk("t5_awvalid_now", 64'(awvalid), 64'd0);
    chk("t5_rsp_valid_now", 64'(rsp_valid), 64'd0);
    tick();
    rst = 1'b0;
    chk("t5_post_bready", 64'(bready), 64'd0);
    chk("t5_post_cmd_ready", 64'(cmd_ready), 64'd1);
    tick();

    // bvalid withheld past counter saturation.
    send(1'b1, 32'h80, 32'hCAFEF00D, 4'hF, 3'b000);
    awready = 1'b1; wready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    repeat (70000) tick();
    bvalid = 1'b1; bresp = 2'd3;
    tick();
    bvalid = 1'b0;
    chk("t6_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("t6_latency_sat", 64'(rsp_latency), 64'hFFFF);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axil_cmd_master.md
# axil_cmd_master

Bridges a simple single-beat command/response interface onto an AXI4-lite master port, issuing one read or write transaction at a time. It sits directly upstream of an AXI-lite slave or interconnect: it is the block that drives the master-port signals monitored by the team's AXI-lite master formal checker. Each response also reports a saturating cycle-latency count for debug and profiling.

## Interface
- DATA_WIDTH, 32, AXI-lite data width in bits.
- ADDR_WIDTH, 32, AXI-lite address width in bits.
- STRB_WIDTH, DATA_WIDTH/8, write-strobe width.
- LAT_WIDTH, 16, width of the latency counter and `rsp_latency`.
- clk  in  1  single clock; all logic is clocked on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid, cmd_ready  in/out  1  command handshake.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_wstrb  in  STRB_WIDTH  write strobes.
- cmd_prot  in  3  protection bits, copied to awprot/arprot.
- rsp_valid, rsp_ready  out/in  1  response handshake.
- rsp_write  out  1  echoes cmd_write.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  bresp or rresp.
- rsp_latency  out  LAT_WIDTH  cycles from command accept to B/R handshake.
- m_axil_aw*, w*, b*, ar*, r*  AXI4-lite master port: awaddr, awprot, awvalid, awready, wdata, wstrb, wvalid, wready, bresp, bvalid, bready, araddr, arprot, arvalid, arready, rdata, rresp, rvalid, rready. Widths follow the parameters.

## Operation
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE: cmd_ready = 1; cmd_ready is combinational, (state==IDLE). The command is accepted on cmd_valid && cmd_ready.
  - Write command: latch addr, wdata, wstrb, and prot; set awvalid=1 and wvalid=1; go to WR_REQ.
  - Read command: latch addr and prot; set arvalid=1; go to RD_REQ.
- WR_REQ: awvalid and wvalid each clear independently on their own handshake. When both have completed (including in the same cycle), go to WR_RESP with bready=1 registered.
- WR_RESP: on bvalid && bready, load rsp_resp=bresp, rsp_rdata=0, rsp_write=1, rsp_valid=1; clear bready; go to RSP.
- RD_REQ: on arvalid && arready, clear arvalid, set rready=1, and go to RD_RESP.
- RD_RESP: on rvalid && rready, load rsp_rdata=rdata, rsp_resp=rresp, rsp_write=0, rsp_valid=1; clear rready; go to RSP.
- RSP: hold all rsp_* stable until rsp_ready, then clear rsp_valid and go to IDLE. No new command is accepted while a response is pending.
- Address, data, strobe, and prot outputs are loaded only at command accept. They stay stable while valid is high and hold their last value otherwise.
- bready is high only in WR_RESP and rready only in RD_RESP. A bvalid or rvalid arriving earlier is ignored, which makes at most one transaction outstanding per channel.
- Latency counter:
  - Cleared to 0 at command accept.
  - Increments by 1 every cycle in WR_REQ, WR_RESP, RD_REQ, and RD_RESP, saturating at all-ones.
  - On the B/R handshake, rsp_latency <= sat(counter+1).

## Timing
- Reset values, applied asynchronously: state=IDLE; every AXI valid/ready output = 0; all addr/data/strb/prot outputs = 0; rsp_valid=0; rsp_* = 0; counter=0.
- Reset mid-transaction abandons the transfer. The first post-reset cycle has all valids and readies low; the downstream slave shares rst.
- All AXI and rsp outputs are registered; only cmd_ready is combinational.
- Minimum command-to-response: command accepted in cycle 0; AW, W, or AR valid in cycle 1; bready or rready in cycle 2; rsp_valid in cycle 3; rsp_latency = 2.
- Back-to-back commands: the next command is accepted in the cycle after the rsp handshake, so throughput is at most one transaction per 4 cycles.
- Stall rules:
  - awvalid, wvalid, and arvalid never deassert before their handshake; the payload is stable.
  - rsp_valid never deasserts before rsp_ready.

## Test plan
- Write addr=0x10, wdata=0xA5A5A5A5, wstrb=0xF, with awready, wready, and bvalid always high and bresp=0 -> AW and W handshake in cycle 1, rsp_valid in cycle 3, rsp_write=1, rsp_resp=0, rsp_latency=2.
- Write with wready=1 and awready held low for 3 cycles -> wvalid drops after cycle 1; awvalid and awaddr stay stable for cycles 1-4; bready rises in cycle 5; bvalid in cycle 5 gives rsp_latency=5.
- Read addr=0x20 with rvalid delayed 4 cycles, rdata=0xDEADBEEF, rresp=2 -> rready held high until the handshake; rsp_rdata=0xDEADBEEF, rsp_resp=2, rsp_latency=6.
- rsp_ready held low for 10 cycles with cmd_valid high -> cmd_ready=0 and no AW or AR valid throughout; the next command is accepted in the cycle after rsp_ready.
- Assert rst while in WR_RESP -> all AXI valids, bready, and rsp_valid read 0 immediately and in the first post-reset cycle; state is IDLE and cmd_ready=1.
- bvalid withheld for 70000 cycles -> rsp_latency=0xFFFF (saturated, no wrap).
